// File: rtl/rv_sdram_bridge_if.sv
// Bus bundles for rv_sdram_bridge: the RV core memory port, and the toggle-handshake
// halfword port toward the SDRAM arbiter (busy travels with the arbiter side).
interface rv_sdram_bridge_mem_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

interface rv_sdram_bridge_sdram_if;
  logic [22:0] rv_addr;
  logic        rv_word;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_we;
  logic        rv_req;
  logic        rv_req_ack;
  logic [15:0] rv_dout;
  logic        busy;

  modport master (
    output rv_addr, rv_word, rv_din, rv_ds, rv_we, rv_req,
    input  rv_req_ack, rv_dout, busy
  );

  modport slave (
    input  rv_addr, rv_word, rv_din, rv_ds, rv_we, rv_req,
    output rv_req_ack, rv_dout, busy
  );
endinterface

// File: rtl/rv_sdram_bridge.sv
// Splits 32-bit RV core accesses into one or two halfword toggle-handshake requests.
// Optional WAIT watchdog enabled by defining RV_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for mem_valid with SDRAM init finished
// ISSUE   | halfword request fields stable, toggle rv_req
// WAIT    | waiting for rv_req_ack to match rv_req
// CAPTURE | rv_dout valid; store read half, pick next halfword
// DONE    | one-cycle mem_ready (and err on timeout)
module rv_sdram_bridge #(
  parameter int TIMEOUT  = 1024,
  parameter int WIN_BITS = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  rv_sdram_bridge_mem_if.slave    mem,
  rv_sdram_bridge_sdram_if.master sdram,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        is_write;
  logic        req_match;
  logic        wd_fire;
  logic        pend_hi;
  logic [15:0] wdata_hi;
  logic [1:0]  wstrb_hi;
  logic        unused_addr;

  assign is_write    = |mem.mem_wstrb;
  assign accept      = (state == IDLE) && mem.mem_valid && !sdram.busy;
  assign req_match   = (sdram.rv_req == sdram.rv_req_ack);
  assign mem.mem_ready = (state == DONE);
  assign unused_addr = ^{mem.mem_addr[31:WIN_BITS], mem.mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT: begin
        if (req_match)    state_nx = CAPTURE;
        else if (wd_fire) state_nx = DONE;
      end
      CAPTURE: state_nx = pend_hi ? ISSUE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdram.rv_addr <= '0;
      sdram.rv_word <= 1'b0;
      sdram.rv_din  <= '0;
      sdram.rv_ds   <= '0;
      sdram.rv_we   <= 1'b0;
      sdram.rv_req  <= 1'b0;
      mem.mem_rdata <= '0;
      wdata_hi      <= '0;
      wstrb_hi      <= '0;
      pend_hi       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sdram.rv_addr <= 23'({mem.mem_addr[WIN_BITS-1:2], 2'b00});
            sdram.rv_we   <= is_write;
            wdata_hi      <= mem.mem_wdata[31:16];
            wstrb_hi      <= mem.mem_wstrb[3:2];
            mem.mem_rdata <= '0;
            // Reads always take both halves; writes skip a half with no strobes.
            if (!is_write || (mem.mem_wstrb[1:0] != 2'b00)) begin
              sdram.rv_word <= 1'b0;
              sdram.rv_din  <= is_write ? mem.mem_wdata[15:0] : 16'h0;
              sdram.rv_ds   <= is_write ? mem.mem_wstrb[1:0] : 2'b11;
              pend_hi       <= !is_write || (mem.mem_wstrb[3:2] != 2'b00);
            end else begin
              sdram.rv_word <= 1'b1;
              sdram.rv_din  <= mem.mem_wdata[31:16];
              sdram.rv_ds   <= mem.mem_wstrb[3:2];
              pend_hi       <= 1'b0;
            end
          end
        end
        ISSUE: sdram.rv_req <= ~sdram.rv_req;
        WAIT: begin
          if (wd_fire) begin
            sdram.rv_req <= sdram.rv_req_ack;
            if (!sdram.rv_we) mem.mem_rdata <= '1;
          end
        end
        CAPTURE: begin
          if (!sdram.rv_we) begin
            if (sdram.rv_word) mem.mem_rdata[31:16] <= sdram.rv_dout;
            else               mem.mem_rdata[15:0]  <= sdram.rv_dout;
          end
          if (pend_hi) begin
            sdram.rv_word <= 1'b1;
            sdram.rv_din  <= sdram.rv_we ? wdata_hi : 16'h0;
            sdram.rv_ds   <= sdram.rv_we ? wstrb_hi : 2'b11;
            pend_hi       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RV_BRIDGE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] watchdog;
  logic            timed_out;

  // Down-counter reloaded per halfword; terminal count in WAIT aborts the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      watchdog  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (accept)       timed_out <= 1'b0;
      else if (wd_fire) timed_out <= 1'b1;
      if (state == ISSUE)
        watchdog <= WD_W'(TIMEOUT - 1);
      else if ((state == WAIT) && (watchdog != '0))
        watchdog <= watchdog - 1'b1;
    end
  end

  assign wd_fire = (state == WAIT) && !req_match && (watchdog == '0);
  assign err     = (state == DONE) && timed_out;
`else
  logic unused_cfg;

  assign unused_cfg = ^(32'(TIMEOUT));
  assign wd_fire    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Scoreboard bench for rv_sdram_bridge with a toggle-handshake SDRAM arbiter model.
module tb_rv_sdram_bridge;
  localparam int TO = 16;

  typedef struct packed {
    logic [22:0] addr;
    logic        word;
    logic [15:0] din;
    logic [1:0]  ds;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic err;

  rv_sdram_bridge_mem_if   m_if ();
  rv_sdram_bridge_sdram_if s_if ();

  rv_sdram_bridge #(.TIMEOUT(TO), .WIN_BITS(21)) dut (
    .clk   (clk),
    .reset (rst),
    .mem   (m_if),
    .sdram (s_if),
    .err   (err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  req_t exp_req_q[$];
  logic [15:0] dout_q[$];
  rsp_t exp_rsp_q[$];

  int   ack_delay  = 0;
  bit   arb_mute   = 1'b0;
  bit   arb_active = 1'b0;
  int   arb_cnt    = 0;
  int   toggles    = 0;
  logic arb_req;
  req_t snap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic req_t cur_req();
    req_t r;
    r.addr = s_if.rv_addr;
    r.word = s_if.rv_word;
    r.din  = s_if.rv_din;
    r.ds   = s_if.rv_ds;
    r.we   = s_if.rv_we;
    return r;
  endfunction

  // Arbiter model: acks ack_delay cycles after first seeing a new toggle.
  always @(negedge clk) begin : arb_model
    req_t cur;
    req_t er;
    cur = cur_req();
    if (rst) begin
      s_if.rv_req_ack = 1'b0;
      s_if.rv_dout    = 16'h0;
      arb_active      = 1'b0;
      arb_cnt         = 0;
      exp_req_q.delete();
      dout_q.delete();
    end else if (s_if.rv_req == s_if.rv_req_ack) begin
      arb_active = 1'b0;
    end else begin
      if (!arb_active) begin
        arb_active = 1'b1;
        arb_cnt    = 0;
        arb_req    = s_if.rv_req;
        snap       = cur;
        toggles++;
        if (exp_req_q.size() == 0) begin
          check_eq("unexpected_req", 32'd1, 32'd0);
        end else begin
          er = exp_req_q.pop_front();
          check_eq("req_addr", 32'(cur.addr), 32'(er.addr));
          check_eq("req_word", 32'(cur.word), 32'(er.word));
          check_eq("req_ds",   32'(cur.ds),   32'(er.ds));
          check_eq("req_we",   32'(cur.we),   32'(er.we));
          if (er.we) check_eq("req_din", 32'(cur.din), 32'(er.din));
        end
      end else begin
        check_eq("req_hold", 32'(s_if.rv_req), 32'(arb_req));
        check_eq("req_stable", 32'({cur.addr, cur.word, cur.ds, cur.we}),
                 32'({snap.addr, snap.word, snap.ds, snap.we}));
        check_eq("din_stable", 32'(cur.din), 32'(snap.din));
      end
      if (!arb_mute) begin
        if (arb_cnt >= ack_delay) begin
          if (!snap.we && dout_q.size() > 0) s_if.rv_dout = dout_q.pop_front();
          else                               s_if.rv_dout = 16'h0;
          s_if.rv_req_ack = s_if.rv_req;
        end else begin
          arb_cnt++;
        end
      end
    end
  end

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_ready"},  32'(m_if.mem_ready), 32'd0);
    check_eq({pfx, "_rdata"},  m_if.mem_rdata,      32'd0);
    check_eq({pfx, "_rv_req"}, 32'(s_if.rv_req),    32'd0);
    check_eq({pfx, "_rv_we"},  32'(s_if.rv_we),     32'd0);
    check_eq({pfx, "_rv_ds"},  32'(s_if.rv_ds),     32'd0);
    check_eq({pfx, "_rv_word"},32'(s_if.rv_word),   32'd0);
    check_eq({pfx, "_rv_din"}, 32'(s_if.rv_din),    32'd0);
    check_eq({pfx, "_rv_addr"},32'(s_if.rv_addr),   32'd0);
    check_eq({pfx, "_err"},    32'(err),            32'd0);
  endtask

  // Called #1 after a rising edge with the bridge in IDLE.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [15:0] d_lo,
                        input logic [15:0] d_hi, input int delay, input int busy_cyc,
                        input bit hold, input bit drop, input bit expect_to);
    req_t        r;
    rsp_t        e;
    int          hw;
    int          n;
    int          tog0;
    bit          is_wr;
    logic [22:0] a;
    is_wr = (wstrb != 4'b0000);
    a     = {2'b00, addr[20:2], 2'b00};
    hw    = 0;
    if (!is_wr || (wstrb[1:0] != 2'b00)) begin
      r = '{addr: a, word: 1'b0, din: wdata[15:0], ds: (is_wr ? wstrb[1:0] : 2'b11), we: is_wr};
      exp_req_q.push_back(r);
      hw++;
    end
    if ((!is_wr || (wstrb[3:2] != 2'b00)) && !(expect_to && hw == 1)) begin
      r = '{addr: a, word: 1'b1, din: wdata[31:16], ds: (is_wr ? wstrb[3:2] : 2'b11), we: is_wr};
      exp_req_q.push_back(r);
      hw++;
    end
    if (!is_wr && !expect_to) begin
      dout_q.push_back(d_lo);
      dout_q.push_back(d_hi);
    end
    e.rdata = is_wr ? 32'h0 : (expect_to ? 32'hFFFF_FFFF : {d_hi, d_lo});
    e.err   = expect_to;
    e.lat   = expect_to ? TO + 1 : hw * (delay + 3);
    exp_rsp_q.push_back(e);

    ack_delay        = delay;
    arb_mute         = expect_to;
    m_if.mem_addr    = addr;
    m_if.mem_wdata   = wdata;
    m_if.mem_wstrb   = wstrb;
    m_if.mem_valid   = 1'b1;
    if (busy_cyc > 0) begin
      s_if.busy = 1'b1;
      tog0 = toggles;
      repeat (busy_cyc) @(posedge clk);
      #1;
      check_eq("busy_hold", 32'(toggles - tog0), 32'd0);
      s_if.busy = 1'b0;
    end
    tog0 = toggles;
    @(posedge clk);
    if (drop) begin
      #1;
      m_if.mem_valid = 1'b0;
      m_if.mem_addr  = ~addr;
      m_if.mem_wdata = ~wdata;
      m_if.mem_wstrb = ~wstrb;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_if.mem_ready && n < 400);
    e = exp_rsp_q.pop_front();
    check_eq("ready_seen", 32'(m_if.mem_ready), 32'd1);
    check_eq("rdata",      m_if.mem_rdata,      e.rdata);
    check_eq("err",        32'(err),            32'(e.err));
    check_eq("latency",    32'(n),              32'(e.lat));
    check_eq("toggles",    32'(toggles - tog0), 32'(hw));
    arb_mute = 1'b0;
    if (!hold) m_if.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_pulse", 32'(m_if.mem_ready), 32'd0);
    check_eq("err_pulse",   32'(err),            32'd0);
  endtask

  initial begin : main
    int         n;
    logic [3:0] ws;
    req_t       r;
    rst            = 1'b1;
    m_if.mem_valid = 1'b0;
    m_if.mem_addr  = '0;
    m_if.mem_wdata = '0;
    m_if.mem_wstrb = '0;
    s_if.busy      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    access(32'h0001_2344, 32'h0, 4'b0000, 16'hBEEF, 16'hDEAD, 2, 0, 1'b0, 1'b0, 1'b0);
    access(32'h0000_1000, 32'h1234_5678, 4'b1100, 16'h0, 16'h0, 1, 0, 1'b0, 1'b0, 1'b0);
    access(32'h001F_FFFC, 32'hA5A5_00C3, 4'b0001, 16'h0, 16'h0, 0, 0, 1'b1, 1'b0, 1'b0);
    access(32'hFFE0_0008, 32'hCAFE_F00D, 4'b1111, 16'h0, 16'h0, 3, 0, 1'b0, 1'b0, 1'b0);
    access(32'h0000_0200, 32'h0, 4'b0000, 16'h1111, 16'h2222, 1, 50, 1'b0, 1'b0, 1'b0);
    access(32'h0004_0010, 32'h0, 4'b0000, 16'h3C3C, 16'h5A5A, 0, 0, 1'b0, 1'b1, 1'b0);
    access(32'h0000_0304, 32'h8765_4321, 4'b0110, 16'h0, 16'h0, 2, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ws = 4'($urandom_range(0, 15));
      access($urandom, $urandom, ws, 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), 0, (i % 2) == 1, 1'b0, 1'b0);
    end

    // Reset while the first halfword of a read sits in WAIT.
    ack_delay = 20;
    r = '{addr: 23'h40, word: 1'b0, din: 16'h0, ds: 2'b11, we: 1'b0};
    exp_req_q.push_back(r);
    m_if.mem_addr  = 32'h0000_0040;
    m_if.mem_wstrb = 4'b0000;
    m_if.mem_valid = 1'b1;
    n = 0;
    while (!arb_active && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rst_reach_wait", 32'(arb_active), 32'd1);
    rst            = 1'b1;
    m_if.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("rstw");
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(32'h0000_0044, 32'h0, 4'b0000, 16'h7777, 16'h8888, 1, 0, 1'b0, 1'b0, 1'b0);

`ifdef RV_BRIDGE_TIMEOUT_EN
    access(32'h0000_0100, 32'h0, 4'b0000, 16'h0, 16'h0, 0, 0, 1'b0, 1'b0, 1'b1);
    check_eq("to_resync", 32'(s_if.rv_req), 32'(s_if.rv_req_ack));
    access(32'h0000_0108, 32'h0, 4'b0000, 16'h1357, 16'h2468, 1, 0, 1'b0, 1'b0, 1'b0);
`endif

    check_eq("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
